// File: rtl/regmodel0_regmodel_smutex0_pkg.sv
// Shared types, error codes and helpers for the smutex0 hardware mutex engine.
package regmodel0_regmodel_smutex0_pkg;

    localparam int unsigned DEF_NUM_MUTEX = 32;
    localparam int unsigned DEF_IDX_W     = 5;
    localparam int unsigned DEF_ID_W      = 6;
    localparam int unsigned DEF_DATA_W    = 32;

    typedef enum logic [1:0] {
        OpLock    = 2'd0,
        OpRelease = 2'd1,
        OpForce   = 2'd2,
        OpRsvd    = 2'd3
    } op_e;

    localparam logic [2:0] ERR_NONE          = 3'd0;
    localparam logic [2:0] ERR_REL_NOT_OWNER = 3'd1;
    localparam logic [2:0] ERR_REL_FREE      = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT       = 3'd3;
    localparam logic [2:0] ERR_FORCE_DENIED  = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL       = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // Age tick period in clocks: 1, 16, 256 or 4096.
    function automatic int unsigned prescale_period(input logic [1:0] prescale);
        return 32'd1 << (4 * prescale);
    endfunction

endpackage

// File: rtl/regmodel0_regmodel_smutex0_age_timer.sv
// Shared prescaler, per-mutex saturating age counters, sticky expiry flags and
// a lowest-index picker for the expiry service path.
module regmodel0_regmodel_smutex0_age_timer
    import regmodel0_regmodel_smutex0_pkg::*;
#(
    parameter int unsigned NUM_MUTEX = DEF_NUM_MUTEX,
    parameter int unsigned IDX_W     = DEF_IDX_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_MUTEX-1:0] held_i,
    input  logic [NUM_MUTEX-1:0] clr_i,
    input  logic [7:0]           compare_i,
    input  logic [1:0]           prescale_i,
    output logic                 expired_any_o,
    output logic [IDX_W-1:0]     expired_idx_o
);

    logic [11:0]          presc_q, presc_d, presc_mask;
    logic                 tick;
    logic [7:0]           age_q [NUM_MUTEX];
    logic [7:0]           age_d [NUM_MUTEX];
    logic [NUM_MUTEX-1:0] exp_q, exp_d;

    always_comb begin
        presc_mask = 12'(prescale_period(prescale_i) - 1);
        presc_d    = presc_q + 12'd1;
        tick       = (presc_q & presc_mask) == presc_mask;
    end

    always_comb begin
        for (int i = 0; i < NUM_MUTEX; i++) begin
            age_d[i] = age_q[i];
            exp_d[i] = exp_q[i];
            if (clr_i[i]) begin
                age_d[i] = 8'd0;
                exp_d[i] = 1'b0;
            end else begin
                if (tick && held_i[i] && (age_q[i] != 8'hFF)) begin
                    age_d[i] = age_q[i] + 8'd1;
                end
                // A zero compare disables timeout and drops any pending expiry.
                if (compare_i == 8'd0) begin
                    exp_d[i] = 1'b0;
                end else if (held_i[i] && (age_q[i] >= compare_i)) begin
                    exp_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        expired_any_o = |exp_q;
        expired_idx_o = '0;
        for (int i = NUM_MUTEX - 1; i >= 0; i--) begin
            if (exp_q[i]) begin
                expired_idx_o = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= 12'd0;
            exp_q   <= '0;
            for (int i = 0; i < NUM_MUTEX; i++) begin
                age_q[i] <= 8'd0;
            end
        end else begin
            presc_q <= presc_d;
            exp_q   <= exp_d;
            for (int i = 0; i < NUM_MUTEX; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/regmodel0_regmodel_smutex0_core.sv
// smutex0 engine: arbitrates lock/release/force requests, services timed-out
// locks and drives owner and error-log register update hooks.
module regmodel0_regmodel_smutex0_core
    import regmodel0_regmodel_smutex0_pkg::*;
#(
    parameter int unsigned NUM_MUTEX = DEF_NUM_MUTEX,
    parameter int unsigned IDX_W     = DEF_IDX_W,
    parameter int unsigned ID_W      = DEF_ID_W,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [IDX_W-1:0]  req_idx_i,
    input  logic [ID_W-1:0]   req_id_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_ok_o,
    output logic [ID_W-1:0]   rsp_owner_o,
    output logic [ID_W-1:0]   owner_id_d_o,
    output logic              owner_id_enb_o,
    input  logic [ID_W-1:0]   ipc_sc_id_q_i,
    input  logic [7:0]        timeout_compare_q_i,
    input  logic [1:0]        timeout_prescale_q_i,
    input  logic [2:0]        err_code_q_i,
    output logic [2:0]        err_code_d_o,
    output logic              err_code_enb_o,
    output logic              err_access_d_o,
    output logic              err_access_enb_o,
    output logic [ID_W-1:0]   err_id_d_o,
    output logic              err_id_enb_o,
    output logic              err_multi_d_o,
    output logic              err_multi_enb_o,
    output logic [DATA_W-1:0] err_data_d_o,
    output logic              err_data_enb_o,
    output logic [IDX_W-1:0]  err_mutex_idx_d_o,
    output logic              err_mutex_idx_enb_o,
    output logic              irq_o
);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ok_q, ok_d;
    logic                irq_q;
    logic [ID_W-1:0]     owner_q [NUM_MUTEX];

    logic                latch;
    logic                owner_wr;
    logic [IDX_W-1:0]    owner_wr_idx;
    logic [ID_W-1:0]     owner_wr_val;
    logic [ID_W-1:0]     cur_owner;
    logic [NUM_MUTEX-1:0] held, clr;
    logic                expired_any;
    logic [IDX_W-1:0]    expired_idx;

    logic                err_fire, err_first;
    logic [2:0]          err_code;
    logic                err_access;
    logic [ID_W-1:0]     err_id;
    logic [DATA_W-1:0]   err_data;
    logic [IDX_W-1:0]    err_idx;

    always_comb begin
        for (int i = 0; i < NUM_MUTEX; i++) begin
            held[i] = owner_q[i] != '0;
        end
    end

    regmodel0_regmodel_smutex0_age_timer #(
        .NUM_MUTEX(NUM_MUTEX),
        .IDX_W    (IDX_W)
    ) u_age_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .held_i       (held),
        .clr_i        (clr),
        .compare_i    (timeout_compare_q_i),
        .prescale_i   (timeout_prescale_q_i),
        .expired_any_o(expired_any),
        .expired_idx_o(expired_idx)
    );

    always_comb begin
        state_d      = state_q;
        ok_d         = ok_q;
        latch        = 1'b0;
        owner_wr     = 1'b0;
        owner_wr_idx = idx_q;
        owner_wr_val = '0;
        clr          = '0;
        cur_owner    = owner_q[idx_q];
        err_fire     = 1'b0;
        err_code     = ERR_NONE;
        err_access   = 1'b0;
        err_id       = '0;
        err_data     = '0;
        err_idx      = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    latch   = 1'b1;
                    state_d = StExec;
                end else if (expired_any) begin
                    // Expiry only uses idle cycles, so it never collides with a request error.
                    owner_wr          = 1'b1;
                    owner_wr_idx      = expired_idx;
                    clr[expired_idx]  = 1'b1;
                    err_fire          = 1'b1;
                    err_code          = ERR_TIMEOUT;
                    err_access        = 1'b1;
                    err_id            = owner_q[expired_idx];
                    err_idx           = expired_idx;
                end
            end
            StExec: begin
                state_d    = StResp;
                ok_d       = 1'b0;
                err_access = op_q != OpLock;
                err_id     = id_q;
                err_data   = wdata_q;
                err_idx    = idx_q;
                if ((id_q == '0) || (op_q == OpRsvd)) begin
                    err_fire = 1'b1;
                    err_code = ERR_ILLEGAL;
                end else begin
                    case (op_q)
                        OpLock: begin
                            if (cur_owner == '0) begin
                                owner_wr     = 1'b1;
                                owner_wr_val = id_q;
                                clr[idx_q]   = 1'b1;
                                ok_d         = 1'b1;
                            end else if (cur_owner == id_q) begin
                                ok_d = 1'b1;
                            end
                        end
                        OpRelease: begin
                            if (cur_owner == id_q) begin
                                owner_wr   = 1'b1;
                                clr[idx_q] = 1'b1;
                                ok_d       = 1'b1;
                            end else begin
                                err_fire = 1'b1;
                                err_code = (cur_owner == '0) ? ERR_REL_FREE : ERR_REL_NOT_OWNER;
                            end
                        end
                        OpForce: begin
                            if ((ipc_sc_id_q_i != '0) && (id_q == ipc_sc_id_q_i)) begin
                                owner_wr   = 1'b1;
                                clr[idx_q] = 1'b1;
                                ok_d       = 1'b1;
                            end else begin
                                err_fire = 1'b1;
                                err_code = ERR_FORCE_DENIED;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o    = state_q == StIdle;
        rsp_valid_o    = state_q == StResp;
        rsp_ok_o       = rsp_valid_o & ok_q;
        rsp_owner_o    = rsp_valid_o ? owner_q[idx_q] : '0;
        owner_id_enb_o = rsp_valid_o;
        owner_id_d_o   = rsp_owner_o;

        // Only the first error is logged in full; later ones just flag multi.
        err_first           = err_fire && (err_code_q_i == ERR_NONE);
        err_code_enb_o      = err_first;
        err_access_enb_o    = err_first;
        err_id_enb_o        = err_first;
        err_data_enb_o      = err_first;
        err_mutex_idx_enb_o = err_first;
        err_code_d_o        = err_first ? err_code : ERR_NONE;
        err_access_d_o      = err_first & err_access;
        err_id_d_o          = err_first ? err_id : '0;
        err_data_d_o        = err_first ? err_data : '0;
        err_mutex_idx_d_o   = err_first ? err_idx : '0;
        err_multi_enb_o     = err_fire && !err_first;
        err_multi_d_o       = err_multi_enb_o;
        irq_o               = irq_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= OpLock;
            idx_q   <= '0;
            id_q    <= '0;
            wdata_q <= '0;
            ok_q    <= 1'b0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_MUTEX; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ok_q    <= ok_d;
            irq_q   <= err_code_q_i != ERR_NONE;
            if (latch) begin
                op_q    <= op_e'(req_op_i);
                idx_q   <= req_idx_i;
                id_q    <= req_id_i;
                wdata_q <= req_wdata_i;
            end
            if (owner_wr) begin
                owner_q[owner_wr_idx] <= owner_wr_val;
            end
        end
    end

endmodule

// File: tb/tb_regmodel0_regmodel_smutex0_core.sv
// Bench for the smutex0 engine: a cycle model of the mutex rules checked every
// cycle, plus directed requests with hand-computed expectations.
module tb_regmodel0_regmodel_smutex0_core;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [4:0]  req_idx = '0;
    logic [5:0]  req_id = '0;
    logic [31:0] req_wdata = '0;
    logic [5:0]  ipc_sc_id_q = '0;
    logic [7:0]  timeout_compare_q = '0;
    logic [1:0]  timeout_prescale_q = '0;
    logic [2:0]  err_code_q = '0;

    logic        req_ready, rsp_valid, rsp_ok, owner_id_enb, irq;
    logic [5:0]  rsp_owner, owner_id_d, err_id_d;
    logic [2:0]  err_code_d;
    logic        err_code_enb, err_access_d, err_access_enb, err_id_enb;
    logic        err_multi_d, err_multi_enb, err_data_enb, err_mutex_idx_enb;
    logic [31:0] err_data_d;
    logic [4:0]  err_mutex_idx_d;

    regmodel0_regmodel_smutex0_core dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_idx_i(req_idx), .req_id_i(req_id), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ok_o(rsp_ok), .rsp_owner_o(rsp_owner),
        .owner_id_d_o(owner_id_d), .owner_id_enb_o(owner_id_enb),
        .ipc_sc_id_q_i(ipc_sc_id_q), .timeout_compare_q_i(timeout_compare_q),
        .timeout_prescale_q_i(timeout_prescale_q), .err_code_q_i(err_code_q),
        .err_code_d_o(err_code_d), .err_code_enb_o(err_code_enb),
        .err_access_d_o(err_access_d), .err_access_enb_o(err_access_enb),
        .err_id_d_o(err_id_d), .err_id_enb_o(err_id_enb),
        .err_multi_d_o(err_multi_d), .err_multi_enb_o(err_multi_enb),
        .err_data_d_o(err_data_d), .err_data_enb_o(err_data_enb),
        .err_mutex_idx_d_o(err_mutex_idx_d), .err_mutex_idx_enb_o(err_mutex_idx_enb),
        .irq_o(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Abstract model: owner table, ages in ticks, expiry flags, request phase.
    int          m_owner[N];
    int          m_age[N];
    bit          m_exp[N];
    int          m_cyc, m_phase, m_op, m_idx, m_id;
    logic [31:0] m_wdata;
    bit          m_ok, m_irq;
    bit          live = 1'b0;

    function automatic void outcome(input int op, input int id, input int cur, input int sup,
                                    output bit ok, output int nxt, output int code);
        ok = 1'b0; nxt = cur; code = 0;
        if (id == 0 || op == 3) code = 5;
        else if (op == 0) begin
            if (cur == 0) begin nxt = id; ok = 1'b1; end
            else if (cur == id) ok = 1'b1;
        end else if (op == 1) begin
            if (cur == id) begin nxt = 0; ok = 1'b1; end
            else code = (cur == 0) ? 2 : 1;
        end else begin
            if (sup != 0 && id == sup) begin nxt = 0; ok = 1'b1; end
            else code = 4;
        end
    endfunction

    function automatic int lowest_expired();
        for (int i = 0; i < N; i++) if (m_exp[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int period, sel, nxt, code;
        bit tick, ok;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_owner[i] = 0; m_age[i] = 0; m_exp[i] = 0; end
            m_cyc = 0; m_phase = 0; m_ok = 0; m_irq = 0; m_idx = 0;
            live = 1'b1;
        end else begin
            period = 1 << (4 * int'(timeout_prescale_q));
            tick = (m_cyc % period) == period - 1;
            sel = lowest_expired();
            for (int i = 0; i < N; i++) begin
                if (timeout_compare_q == 0) m_exp[i] = 0;
                else if (m_owner[i] != 0 && m_age[i] >= int'(timeout_compare_q)) m_exp[i] = 1;
                if (tick && m_owner[i] != 0 && m_age[i] < 255) m_age[i]++;
            end
            case (m_phase)
                0: begin
                    if (req_valid) begin
                        m_op = int'(req_op); m_idx = int'(req_idx); m_id = int'(req_id);
                        m_wdata = req_wdata; m_phase = 1;
                    end else if (sel >= 0) begin
                        m_owner[sel] = 0; m_age[sel] = 0; m_exp[sel] = 0;
                    end
                end
                1: begin
                    outcome(m_op, m_id, m_owner[m_idx], int'(ipc_sc_id_q), ok, nxt, code);
                    if (nxt != m_owner[m_idx]) begin
                        m_owner[m_idx] = nxt; m_age[m_idx] = 0; m_exp[m_idx] = 0;
                    end
                    m_ok = ok; m_phase = 2;
                end
                default: m_phase = 0;
            endcase
            m_irq = err_code_q != 0;
            m_cyc = (m_cyc + 1) % 4096;
        end
    end

    int          h_idx[$], h_id[$], h_code[$], h_cyc[$];
    logic [31:0] h_data[$];
    int          multi_cnt = 0;
    int          ncyc = 0;

    always @(negedge clk) begin : cmp
        bit fire, ok, first;
        int nxt, code, acc, eid, eidx, sel;
        logic [31:0] edata;
        if (live) begin
            fire = 0; code = 0; acc = 0; eid = 0; eidx = 0; edata = '0;
            if (m_phase == 1) begin
                outcome(m_op, m_id, m_owner[m_idx], int'(ipc_sc_id_q), ok, nxt, code);
                fire = code != 0; acc = (m_op != 0); eid = m_id; eidx = m_idx; edata = m_wdata;
            end else if (m_phase == 0 && !req_valid) begin
                sel = lowest_expired();
                if (sel >= 0) begin
                    fire = 1; code = 3; acc = 1; eid = m_owner[sel]; eidx = sel;
                end
            end
            first = fire && err_code_q == 0;
            chk("req_ready", req_ready, m_phase == 0);
            chk("rsp_valid", rsp_valid, m_phase == 2);
            chk("owner_id_enb", owner_id_enb, m_phase == 2);
            if (m_phase == 2) begin
                chk("rsp_ok", rsp_ok, m_ok);
                chk("rsp_owner", rsp_owner, m_owner[m_idx]);
                chk("owner_id_d", owner_id_d, m_owner[m_idx]);
            end
            chk("err_enbs", {err_code_enb, err_access_enb, err_id_enb, err_data_enb,
                             err_mutex_idx_enb, err_multi_enb},
                {first, first, first, first, first, fire && !first});
            if (first) begin
                chk("err_code_d", err_code_d, code);
                chk("err_access_d", err_access_d, acc);
                chk("err_id_d", err_id_d, eid);
                chk("err_data_d", err_data_d, edata);
                chk("err_mutex_idx_d", err_mutex_idx_d, eidx);
            end
            if (fire && !first) chk("err_multi_d", err_multi_d, 1);
            chk("irq", irq, m_irq);
        end
        if (err_code_enb === 1'b1) begin
            h_idx.push_back(int'(err_mutex_idx_d)); h_id.push_back(int'(err_id_d));
            h_code.push_back(int'(err_code_d)); h_data.push_back(err_data_d);
            h_cyc.push_back(ncyc);
        end
        if (err_multi_enb === 1'b1) multi_cnt++;
        ncyc++;
    end

    int   last_lat;
    int   last_owner_d;

    task automatic clear_hist();
        h_idx.delete(); h_id.delete(); h_code.delete(); h_data.delete(); h_cyc.delete();
    endtask

    task automatic do_req(input int op, input int idx, input int id, input logic [31:0] wd,
                          output bit ok, output int own);
        int n;
        @(posedge clk); #2;
        req_valid = 1'b1; req_op = op[1:0]; req_idx = idx[4:0]; req_id = id[5:0]; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #2 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 10);
        last_lat = n;
        if (rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", n);
            ok = 0; own = -1;
        end else begin
            ok = rsp_ok; own = int'(rsp_owner); last_owner_d = int'(owner_id_d);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int own, n, m0, seen;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err_code_enb", err_code_enb, 0);
        chk("rst_owner_id_enb", owner_id_enb, 0);

        do_req(0, 3, 5, 32'h0, ok, own);
        chk("lock_free_ok", ok, 1); chk("lock_free_owner", own, 5);
        chk("lock_owner_id_d", last_owner_d, 5); chk("lock_latency", last_lat, 2);

        clear_hist();
        do_req(0, 3, 7, 32'h0, ok, own);
        chk("lock_busy_ok", ok, 0); chk("lock_busy_owner", own, 5);
        chk("lock_busy_no_err", h_idx.size(), 0);

        clear_hist();
        do_req(1, 3, 7, 32'hA5A5_0001, ok, own);
        chk("rel_other_ok", ok, 0); chk("rel_other_nerr", h_idx.size(), 1);
        chk("rel_other_code", h_code[0], 1); chk("rel_other_id", h_id[0], 7);
        chk("rel_other_idx", h_idx[0], 3); chk("rel_other_data", h_data[0], 32'hA5A5_0001);

        err_code_q = 3'd1;
        clear_hist(); m0 = multi_cnt;
        do_req(1, 3, 7, 32'h1234, ok, own);
        chk("multi_pulse", multi_cnt - m0, 1); chk("multi_keeps_first", h_idx.size(), 0);
        chk("irq_set", irq, 1);
        err_code_q = 3'd0;

        clear_hist();
        do_req(1, 1, 4, 32'hBEEF, ok, own);
        chk("rel_free_ok", ok, 0); chk("rel_free_code", h_code[0], 2);

        clear_hist();
        do_req(0, 4, 0, 32'h55, ok, own);
        chk("illegal_id_ok", ok, 0); chk("illegal_id_owner", own, 0);
        chk("illegal_id_code", h_code[0], 5);
        clear_hist();
        do_req(3, 4, 2, 32'h66, ok, own);
        chk("illegal_op_code", h_code[0], 5); chk("illegal_op_owner", own, 0);

        ipc_sc_id_q = 6'd9;
        clear_hist();
        do_req(2, 3, 4, 32'h77, ok, own);
        chk("force_denied_ok", ok, 0); chk("force_denied_owner", own, 5);
        chk("force_denied_code", h_code[0], 4);
        do_req(2, 3, 9, 32'h0, ok, own);
        chk("force_ok", ok, 1); chk("force_owner", own, 0);
        do_req(2, 10, 9, 32'h0, ok, own);
        chk("force_free_ok", ok, 1);

        do_req(0, 8, 12, 32'h0, ok, own);
        do_req(1, 8, 12, 32'h0, ok, own);
        chk("rel_own_ok", ok, 1); chk("rel_own_owner", own, 0);

        // Two mutexes age past the limit together once compare goes nonzero.
        do_req(0, 2, 11, 32'h0, ok, own);
        do_req(0, 6, 13, 32'h0, ok, own);
        repeat (10) @(posedge clk);
        #2 clear_hist();
        timeout_compare_q = 8'd4;
        n = 0;
        while (h_idx.size() < 2 && n < 20) begin @(negedge clk); n++; end
        chk("tmo_count", h_idx.size(), 2);
        chk("tmo_first_idx", h_idx[0], 2); chk("tmo_first_id", h_id[0], 11);
        chk("tmo_first_code", h_code[0], 3); chk("tmo_first_data", h_data[0], 0);
        chk("tmo_second_idx", h_idx[1], 6); chk("tmo_second_id", h_id[1], 13);
        chk("tmo_back_to_back", h_cyc[1] - h_cyc[0], 1);

        @(posedge clk); #2;
        timeout_compare_q = 8'd0; timeout_prescale_q = 2'd1;
        do_req(0, 20, 3, 32'h0, ok, own);
        @(posedge clk); #2;
        clear_hist(); timeout_compare_q = 8'd2;
        n = 0;
        while (h_idx.size() < 1 && n < 200) begin @(negedge clk); n++; end
        chk("tmo_p16_idx", h_idx[0], 20); chk("tmo_p16_id", h_id[0], 3);
        @(posedge clk); #2;
        timeout_compare_q = 8'd0; timeout_prescale_q = 2'd0;

        do_req(0, 5, 21, 32'h0, ok, own);
        chk("pre_rst_lock", ok, 1);
        @(posedge clk); #2;
        req_valid = 1'b1; req_op = 2'd0; req_idx = 5'd3; req_id = 6'd22;
        @(posedge clk); #2;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid === 1'b1) seen++; end
        chk("rst_abort_no_rsp", seen, 0);
        do_req(0, 5, 30, 32'h0, ok, own);
        chk("post_rst_lock5_ok", ok, 1); chk("post_rst_lock5_owner", own, 30);
        do_req(0, 3, 31, 32'h0, ok, own);
        chk("post_rst_lock3_ok", ok, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
